// File: rtl/product_accumulator.sv
// Accumulates groups of up to Count multiplier products and hands each group sum,
// with its term count, downstream over a valid/ready handshake.
module product_accumulator #(
    parameter int Width = 8,
    parameter int Count = 4,
    localparam int AccWidth = 2 * Width + $clog2(Count),
    localparam int CntWidth = $clog2(Count + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [2*Width-1:0]    in_product_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [AccWidth-1:0]   out_sum_o,
    output logic [CntWidth-1:0]   out_count_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    state_e              state_r, state_s;
    logic [AccWidth-1:0] acc_r, acc_s, sum_r, sum_s, add_s;
    logic [CntWidth-1:0] cnt_r, cnt_s, count_r, count_s, inc_s;
    logic                close_s;

    // Running sum/count including the product currently offered.
    assign add_s   = acc_r + AccWidth'(in_product_i);
    assign inc_s   = cnt_r + CntWidth'(1'b1);
    assign close_s = in_last_i || (inc_s == CntWidth'(Count));

    // Handshake flags come from state alone so neither side sees a combinational path.
    assign in_ready_o  = (state_r == ACCUM);
    assign out_valid_o = (state_r == DONE);
    assign out_sum_o   = sum_r;
    assign out_count_o = count_r;

    // Next-state and datapath update; clear_i overrides every other event.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        sum_s   = sum_r;
        count_s = count_r;
        if (clear_i) begin
            state_s = ACCUM;
            acc_s   = '0;
            cnt_s   = '0;
            sum_s   = '0;
            count_s = '0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (in_valid_i) begin
                        if (close_s) begin
                            sum_s   = add_s;
                            count_s = inc_s;
                            acc_s   = '0;
                            cnt_s   = '0;
                            state_s = DONE;
                        end else begin
                            acc_s = add_s;
                            cnt_s = inc_s;
                        end
                    end else begin
                        state_s = ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_s = ACCUM;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = ACCUM;
                    acc_s   = '0;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ACCUM;
            acc_r   <= '0;
            cnt_r   <= '0;
            sum_r   <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            sum_r   <= sum_s;
            count_r <= count_s;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed vector table, hand-written
// corner sequences and a randomized scoreboard run against a queue-based reference.
module tb_product_accumulator;

    localparam int W = 8;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] prod;
    logic        last;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] out_sum;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    product_accumulator #(.Width(W), .Count(C)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_product_i(prod),
        .in_last_i   (last),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_sum_o   (out_sum),
        .out_count_o (out_count),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0] p;
        int n;
        int exp_sum;
        int exp_cnt;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   pops = 0;
    bit   rand_rdy = 1'b0;
    int   part_sum = 0;
    int   part_n = 0;
    int   exp_sum_q[$];
    int   exp_cnt_q[$];
    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: decides from the handshake about to happen at the next edge.
    task automatic tick();
        if (!rst_n || clear) begin
            part_sum = 0;
            part_n = 0;
            exp_sum_q.delete();
            exp_cnt_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_sum_q.size() == 0) begin
                    check("sb_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    check("sb_sum", 32'(out_sum), 32'(exp_sum_q.pop_front()));
                    check("sb_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                part_sum += int'(prod);
                part_n++;
                if (last || part_n == C) begin
                    exp_sum_q.push_back(part_sum);
                    exp_cnt_q.push_back(part_n);
                    part_sum = 0;
                    part_n = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] p, input logic l);
        int k;
        prod = p;
        last = l;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    function automatic vec_t mk(int n, int a, int b, int c, int d, int s, int k);
        vec_t v;
        v.p[0] = 16'(a);
        v.p[1] = 16'(b);
        v.p[2] = 16'(c);
        v.p[3] = 16'(d);
        v.n = n;
        v.exp_sum = s;
        v.exp_cnt = k;
        return v;
    endfunction

    initial begin
        int n;
        int gap;
        int pops0;
        vecs[0] = mk(4, 10, 20, 30, 40, 100, 4);
        vecs[1] = mk(2, 65025, 65025, 0, 0, 130050, 2);
        vecs[2] = mk(4, 65025, 65025, 65025, 65025, 260100, 4);
        vecs[3] = mk(1, 7, 0, 0, 0, 7, 1);
        vecs[4] = mk(3, 0, 0, 0, 0, 0, 3);
        vecs[5] = mk(3, 65535, 1, 65535, 0, 131071, 3);

        rst_n = 1'b0;
        clear = 1'b0;
        prod = 16'd0;
        last = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table: last asserted on the final term only for short groups.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                send(vecs[i].p[j], (j == vecs[i].n - 1) && (vecs[i].n < C));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_count", i), 32'(out_count), 32'(vecs[i].exp_cnt));
            tick();
            check($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_in_ready_back", i), 32'(in_ready), 32'd1);
        end

        // Backpressure with input pressing against a full stage.
        out_ready = 1'b0;
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        prod = 16'd99;
        last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(out_sum), 32'd10);
            check("bp_count", 32'(out_count), 32'd4);
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        last = 1'b0;
        tick();
        check("bp_release", 32'(out_valid), 32'd0);
        send(16'd5, 1'b1);
        check("bp_next_sum", 32'(out_sum), 32'd5);
        check("bp_next_count", 32'(out_count), 32'd1);
        tick();

        // Clear mid-group, with a discarded product offered the same cycle.
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        clear = 1'b1;
        prod = 16'd50;
        in_valid = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", 32'(out_valid), 32'd0);
        send(16'd5, 1'b1);
        check("clr_sum", 32'(out_sum), 32'd5);
        check("clr_count", 32'(out_count), 32'd1);
        tick();

        // Clear drops a pending result.
        out_ready = 1'b0;
        send(16'd9, 1'b1);
        check("clr_done_valid", 32'(out_valid), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_done_drop", 32'(out_valid), 32'd0);
        check("clr_done_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Asynchronous reset mid-group.
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_sum", 32'(out_sum), 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        send(16'd5, 1'b1);
        check("arst_after_sum", 32'(out_sum), 32'd5);
        check("arst_after_count", 32'(out_count), 32'd1);
        tick();

        // Gapped input.
        send(16'd3, 1'b0);
        tick();
        tick();
        send(16'd4, 1'b0);
        tick();
        send(16'd5, 1'b1);
        check("gap_sum", 32'(out_sum), 32'd12);
        check("gap_count", 32'(out_count), 32'd3);
        tick();

        // Random groups, gaps and backpressure against the scoreboard.
        pops0 = pops;
        rand_rdy = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            n = $urandom_range(1, C);
            for (int j = 0; j < n; j++) begin
                gap = $urandom_range(0, 2);
                for (int k = 0; k < gap; k++) tick();
                send(16'($urandom), (j == n - 1) ? ((n < C) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0);
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rand_groups", 32'(pops - pops0), 32'd1000);
        check("rand_queue_empty", 32'(exp_sum_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
